// File: rtl/stochastic_gen.sv
// stochastic_gen: binary-to-stochastic converter (SNG).
// Encodes an N_count-bit unsigned value as a unipolar bitstream over windows
// of 2^N_count enabled cycles. Each window carries exactly as many ones as
// the value sampled at its first enabled cycle.
//
// Parameters:
//   N_count  value width, window = 2^N_count enabled cycles (4..12)
//   MODE     0 = LFSR comparand, 1 = bit-reversed counter comparand
//   SEED     LFSR start state (0 is replaced by 1)
// Ports:
//   CLK           clock, all state on posedge
//   RESET         synchronous active-high reset, highest priority
//   ENABLE        advance one stream bit per clock when high
//   in            value to encode, sampled at window start
//   out           registered stochastic bit
//   WINDOW_START  high with the first bit of a window
//   WINDOW_END    high with the last bit of a window
//   val_q         value encoded in the current window
module stochastic_gen #(
  parameter int N_count = 8,
  parameter int MODE    = 0,
  parameter int SEED    = 1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               ENABLE,
  input  logic [N_count-1:0] in,
  output logic               out,
  output logic               WINDOW_START,
  output logic               WINDOW_END,
  output logic [N_count-1:0] val_q
);

  if (N_count < 4 || N_count > 12) begin : g_bad_width
    $error("stochastic_gen: N_count must be in 4..12");
  end
  if (MODE != 0 && MODE != 1) begin : g_bad_mode
    $error("stochastic_gen: MODE must be 0 or 1");
  end

  // Fibonacci XOR taps from the max-length table; bit (t-1) set for tap t.
  localparam logic [11:0] TAPS =
    (N_count == 4)  ? 12'h00C :
    (N_count == 5)  ? 12'h014 :
    (N_count == 6)  ? 12'h030 :
    (N_count == 7)  ? 12'h060 :
    (N_count == 8)  ? 12'h0B8 :
    (N_count == 9)  ? 12'h110 :
    (N_count == 10) ? 12'h240 :
    (N_count == 11) ? 12'h500 : 12'h829;
  localparam logic [N_count-1:0] TAP_MASK = TAPS[N_count-1:0];
  localparam logic [N_count-1:0] MAXC     = '1;
  localparam logic [N_count-1:0] ONE      = {{(N_count-1){1'b0}}, 1'b1};
  localparam logic [N_count-1:0] SEED_T   = SEED[N_count-1:0];
  localparam logic [N_count-1:0] SEED_EFF = (SEED_T == '0) ? ONE : SEED_T;

  logic [N_count-1:0] cnt, lfsr, lfsr_nxt, rev, v, c;
  logic               at_start, at_end;

  assign at_start = (cnt == '0);
  assign at_end   = (cnt == MAXC);
  assign lfsr_nxt = {lfsr[N_count-2:0], ^(lfsr & TAP_MASK)};
  assign v        = at_start ? in : val_q;

  always_comb begin
    rev = '0;
    for (int i = 0; i < N_count; i++) rev[i] = cnt[N_count-1-i];
  end

  // MODE 0: lfsr visits 1..2^N-1 once per window, so lfsr-1 covers
  // 0..2^N-2; the last slot supplies the missing all-ones comparand.
  if (MODE == 1) begin : g_rev
    assign c = rev;
  end else begin : g_lfsr
    assign c = at_end ? MAXC : (lfsr - ONE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt          <= '0;
      lfsr         <= SEED_EFF;
      val_q        <= '0;
      out          <= 1'b0;
      WINDOW_START <= 1'b0;
      WINDOW_END   <= 1'b0;
    end else if (ENABLE) begin
      if (at_start) val_q <= in;
      // Hold on the last slot: 2^N-1 steps per window brings lfsr back to seed.
      if (!at_end) lfsr <= lfsr_nxt;
      out          <= (v > c);
      WINDOW_START <= at_start;
      WINDOW_END   <= at_end;
      cnt          <= cnt + ONE;
    end else begin
      // Idle cycles emit zeros so downstream ones-counters stay exact.
      out          <= 1'b0;
      WINDOW_START <= 1'b0;
      WINDOW_END   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stochastic_gen.sv
// Bench for stochastic_gen: MODE 0 and MODE 1 instances share stimulus.
// A window-position model checks strobes, val_q, MODE 1 bits and per-window
// ones counts against the sampled value.
module tb_stochastic_gen;

  localparam int N = 8;
  localparam int WL = 1 << N;

  logic         clk = 1'b0;
  logic         reset, enable;
  logic [N-1:0] din;
  logic         out0, ws0, we0, out1, ws1, we1;
  logic [N-1:0] vq0, vq1;

  always #5 clk = ~clk;

  stochastic_gen #(.N_count(N), .MODE(0), .SEED(1)) u0 (
    .CLK(clk), .RESET(reset), .ENABLE(enable), .in(din),
    .out(out0), .WINDOW_START(ws0), .WINDOW_END(we0), .val_q(vq0));

  stochastic_gen #(.N_count(N), .MODE(1), .SEED(1)) u1 (
    .CLK(clk), .RESET(reset), .ENABLE(enable), .in(din),
    .out(out1), .WINDOW_START(ws1), .WINDOW_END(we1), .val_q(vq1));

  int pass = 0, total = 0;
  int pos = 0, ones0 = 0, ones1 = 0;
  logic [N-1:0] tv = '0;
  int bit_bad = 0, strobe_bad = 0, vq_bad = 0, idle_bad = 0;
  int win0[$], win1[$];

  function automatic int bitrev(input int k);
    int r = 0;
    for (int i = 0; i < N; i++) r = r * 2 + ((k >> i) & 1);
    return r;
  endfunction

  // One clock of stimulus; updates the reference model and tallies
  // per-cycle discrepancies for the test tasks to judge.
  task automatic clk_cycle(input logic en, input logic rst, input logic [N-1:0] v);
    logic ews, ewe;
    enable = en; reset = rst; din = v;
    @(posedge clk); #1;
    if (rst) begin
      pos = 0; ones0 = 0; ones1 = 0;
    end else if (!en) begin
      if ((out0 | ws0 | we0 | out1 | ws1 | we1) !== 1'b0) idle_bad++;
    end else begin
      if (pos == 0) tv = v;
      ews = (pos == 0);
      ewe = (pos == WL - 1);
      if (ws0 !== ews || we0 !== ewe || ws1 !== ews || we1 !== ewe) strobe_bad++;
      if (out1 !== (int'(tv) > bitrev(pos))) bit_bad++;
      if (vq0 !== tv || vq1 !== tv) vq_bad++;
      ones0 += int'(out0);
      ones1 += int'(out1);
      if (pos == WL - 1) begin
        win0.push_back(ones0); win1.push_back(ones1);
        ones0 = 0; ones1 = 0; pos = 0;
      end else pos++;
    end
  endtask

  // Runs until one window completes; in = v0 before position chg, v1 after.
  task automatic run_window(input logic [N-1:0] v0, input logic [N-1:0] v1,
                            input int chg, input int en_pct,
                            output int c0, output int c1);
    int start, guard;
    start = win0.size(); guard = 0;
    while (win0.size() == start && guard < 4000) begin
      clk_cycle($urandom_range(99) < en_pct, 1'b0, (pos < chg) ? v0 : v1);
      guard++;
    end
    if (win0.size() > start) begin
      c0 = win0.pop_back(); c1 = win1.pop_back();
    end else begin
      c0 = -1; c1 = -1;
    end
  endtask

  task automatic clear_tallies();
    bit_bad = 0; strobe_bad = 0; vq_bad = 0; idle_bad = 0;
  endtask

  task automatic test_reset();
    clk_cycle(1'b1, 1'b1, 8'hA5);
    clk_cycle(1'b1, 1'b1, 8'h5A);
    total++; if ({out0, ws0, we0} !== 3'b000) $display("FAIL reset_out0 got %b want 000", {out0, ws0, we0}); else pass++;
    total++; if ({out1, ws1, we1} !== 3'b000) $display("FAIL reset_out1 got %b want 000", {out1, ws1, we1}); else pass++;
    total++; if (vq0 !== 8'd0) $display("FAIL reset_vq0 got %0d want 0", vq0); else pass++;
    total++; if (vq1 !== 8'd0) $display("FAIL reset_vq1 got %0d want 0", vq1); else pass++;
  endtask

  task automatic test_mode1_basic();
    int c0, c1;
    clear_tallies();
    run_window(8'd100, 8'd100, WL, 100, c0, c1);
    total++; if (c1 !== 100) $display("FAIL m1_count got %0d want 100", c1); else pass++;
    total++; if (c0 !== 100) $display("FAIL m0_count got %0d want 100", c0); else pass++;
    total++; if (bit_bad !== 0) $display("FAIL m1_bits got %0d bad want 0", bit_bad); else pass++;
    total++; if (strobe_bad !== 0) $display("FAIL basic_strobes got %0d bad want 0", strobe_bad); else pass++;
  endtask

  task automatic test_values();
    logic [N-1:0] vals [4];
    int c0, c1;
    vals[0] = 8'd0; vals[1] = 8'd255; vals[2] = 8'd100; vals[3] = N'($urandom_range(255));
    clear_tallies();
    for (int i = 0; i < 4; i++) begin
      run_window(vals[i], vals[i], WL, 100, c0, c1);
      total++; if (c0 !== int'(vals[i])) $display("FAIL values_m0 got %0d want %0d", c0, vals[i]); else pass++;
      total++; if (c1 !== int'(vals[i])) $display("FAIL values_m1 got %0d want %0d", c1, vals[i]); else pass++;
    end
    total++; if (vq_bad !== 0) $display("FAIL values_valq got %0d bad want 0", vq_bad); else pass++;
  endtask

  task automatic test_input_change();
    int c0, c1;
    clear_tallies();
    run_window(8'd37, 8'd200, 10, 100, c0, c1);
    total++; if (c0 !== 37) $display("FAIL chg_first_m0 got %0d want 37", c0); else pass++;
    total++; if (c1 !== 37) $display("FAIL chg_first_m1 got %0d want 37", c1); else pass++;
    run_window(8'd200, 8'd200, WL, 100, c0, c1);
    total++; if (c0 !== 200) $display("FAIL chg_next_m0 got %0d want 200", c0); else pass++;
    total++; if (c1 !== 200) $display("FAIL chg_next_m1 got %0d want 200", c1); else pass++;
    total++; if (vq_bad !== 0) $display("FAIL chg_valq got %0d bad want 0", vq_bad); else pass++;
  endtask

  task automatic test_enable_toggle();
    int c0, c1, n;
    clear_tallies();
    n = win0.size();
    for (int i = 0; i < 2 * WL; i++) clk_cycle((i % 2) == 0, 1'b0, 8'd100);
    c0 = -1; c1 = -1;
    if (win0.size() > n) begin c0 = win0.pop_back(); c1 = win1.pop_back(); end
    total++; if (c0 !== 100) $display("FAIL toggle_m0 got %0d want 100", c0); else pass++;
    total++; if (c1 !== 100) $display("FAIL toggle_m1 got %0d want 100", c1); else pass++;
    total++; if (idle_bad !== 0) $display("FAIL toggle_idle got %0d bad want 0", idle_bad); else pass++;
    total++; if (strobe_bad !== 0) $display("FAIL toggle_strobes got %0d bad want 0", strobe_bad); else pass++;
  endtask

  task automatic test_reset_midwindow();
    int c0, c1;
    clear_tallies();
    for (int i = 0; i < 77; i++) clk_cycle(1'b1, 1'b0, 8'd50);
    clk_cycle(1'b1, 1'b1, 8'd50);
    total++; if ({out0, ws0, we0, out1, ws1, we1} !== 6'b0) $display("FAIL midrst_out got %b want 000000", {out0, ws0, we0, out1, ws1, we1}); else pass++;
    total++; if (vq0 !== 8'd0 || vq1 !== 8'd0) $display("FAIL midrst_valq got %0d/%0d want 0/0", vq0, vq1); else pass++;
    run_window(8'd100, 8'd100, WL, 100, c0, c1);
    total++; if (c0 !== 100) $display("FAIL midrst_m0 got %0d want 100", c0); else pass++;
    total++; if (c1 !== 100) $display("FAIL midrst_m1 got %0d want 100", c1); else pass++;
    total++; if (strobe_bad !== 0) $display("FAIL midrst_strobes got %0d bad want 0", strobe_bad); else pass++;
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] vals [4];
    int c0, c1;
    vals[0] = 8'd0; vals[1] = 8'd1; vals[2] = 8'd128; vals[3] = 8'd255;
    clear_tallies();
    for (int i = 0; i < 4; i++) begin
      run_window(vals[i], vals[i], WL, 100, c0, c1);
      total++; if (c0 !== int'(vals[i])) $display("FAIL b2b_m0 got %0d want %0d", c0, vals[i]); else pass++;
      total++; if (c1 !== int'(vals[i])) $display("FAIL b2b_m1 got %0d want %0d", c1, vals[i]); else pass++;
    end
    total++; if (strobe_bad !== 0) $display("FAIL b2b_strobes got %0d bad want 0", strobe_bad); else pass++;
    total++; if (bit_bad !== 0) $display("FAIL b2b_bits got %0d bad want 0", bit_bad); else pass++;
  endtask

  task automatic test_random();
    logic [N-1:0] v0, v1;
    int c0, c1;
    clear_tallies();
    for (int i = 0; i < 4; i++) begin
      v0 = N'($urandom_range(255));
      v1 = N'($urandom_range(255));
      run_window(v0, v1, $urandom_range(1, WL - 1), 70, c0, c1);
      total++; if (c0 !== int'(v0)) $display("FAIL rand_m0 got %0d want %0d", c0, v0); else pass++;
      total++; if (c1 !== int'(v0)) $display("FAIL rand_m1 got %0d want %0d", c1, v0); else pass++;
    end
    total++; if (idle_bad + strobe_bad + bit_bad + vq_bad !== 0)
      $display("FAIL rand_cycles got idle=%0d strobe=%0d bit=%0d valq=%0d want all 0",
               idle_bad, strobe_bad, bit_bad, vq_bad);
    else pass++;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; din = '0;
    test_reset();
    test_mode1_basic();
    test_values();
    test_input_change();
    test_enable_toggle();
    test_reset_midwindow();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
